// File: rtl/int_ctrl.sv
// int_ctrl: machine-mode interrupt controller for a single-issue pipeline.
// Arbitrates the external/software/timer requests and waits for a safe point
// (no stall and no pending jump). It then issues one redirect pulse into the
// trap vector together with the mepc/mcause/mie CSR update strobes. A later
// MRET issues one return pulse back to mepc.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   ext/sw/tmr_irq_i         level-sensitive interrupt requests
//   mstatus_mie_i, mie_i     global enable and per-source enables {ext,sw,tmr}
//   mtvec_i                  trap vector CSR
//   pc_i, jump_en_i,
//   jump_addr_i, stall_i     pipeline control view
//   mret_i, mepc_i           MRET retiring in EXE and current mepc value
//   int_en_o, isr_pc_o       redirect/flush pulse and its target
//   mepc_we_o, mepc_o, mcause_we_o, mcause_o, mie_clr_o, mie_set_o
//                            CSR update strobes and data
//
// Configuration macro: INT_VECTORED_EN. When it is defined, mtvec mode 2'b01
// selects the vectored target base + 4*code. By default the target is always
// the base.
module int_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ext_irq_i,
  input  logic                  sw_irq_i,
  input  logic                  tmr_irq_i,
  input  logic                  mstatus_mie_i,
  input  logic [2:0]            mie_i,
  input  logic [ADDR_WIDTH-1:0] mtvec_i,
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic                  jump_en_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  input  logic                  stall_i,
  input  logic                  mret_i,
  input  logic [ADDR_WIDTH-1:0] mepc_i,
  output logic                  int_en_o,
  output logic [ADDR_WIDTH-1:0] isr_pc_o,
  output logic                  mepc_we_o,
  output logic [ADDR_WIDTH-1:0] mepc_o,
  output logic                  mcause_we_o,
  output logic [31:0]           mcause_o,
  output logic                  mie_clr_o,
  output logic                  mie_set_o
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitSafe,
    StIssue,
    StActive,
    StRet
  } state_e;

  state_e state_q, state_d;
  logic [31:0] mcause_q;

  logic [2:0]            pend;
  logic                  safe;
  logic [3:0]            code;
  logic [ADDR_WIDTH-1:0] trap_base;
  logic [ADDR_WIDTH-1:0] trap_target;

  // Request qualification and fixed-priority arbitration: ext > sw > tmr.
  always_comb begin
    pend = {ext_irq_i, sw_irq_i, tmr_irq_i} & mie_i & {3{mstatus_mie_i}};
    safe = !stall_i && !jump_en_i;
    if (pend[2]) begin
      code = 4'd11;
    end else if (pend[1]) begin
      code = 4'd3;
    end else begin
      code = 4'd7;
    end
  end

  // The mask keeps every mtvec bit in use, so the mode bits are simply dropped.
  assign trap_base = mtvec_i & ~ADDR_WIDTH'(2'b11);

`ifdef INT_VECTORED_EN
  assign trap_target = (mtvec_i[1:0] == 2'b01) ?
                       trap_base + ADDR_WIDTH'({mcause_q[3:0], 2'b00}) : trap_base;
`else
  assign trap_target = trap_base;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StWaitSafe: begin
        // Both states re-arbitrate every cycle. A withdrawn request drops back to idle.
        if (pend == 3'b000) begin
          state_d = StIdle;
        end else if (safe) begin
          state_d = StIssue;
        end else begin
          state_d = StWaitSafe;
        end
      end
      StIssue:  state_d = StActive;
      StActive: if (mret_i) state_d = StRet;
      StRet:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    int_en_o    = 1'b0;
    isr_pc_o    = '0;
    mepc_we_o   = 1'b0;
    mepc_o      = '0;
    mcause_we_o = 1'b0;
    mcause_o    = mcause_q;
    mie_clr_o   = 1'b0;
    mie_set_o   = 1'b0;
    unique case (state_q)
      StIssue: begin
        int_en_o    = 1'b1;
        isr_pc_o    = trap_target;
        mepc_we_o   = 1'b1;
        // A jump resolving in the issue cycle wins over the sequential PC.
        mepc_o      = jump_en_i ? jump_addr_i : pc_i;
        mcause_we_o = 1'b1;
        mie_clr_o   = 1'b1;
      end
      StRet: begin
        int_en_o  = 1'b1;
        isr_pc_o  = mepc_i;
        mie_set_o = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      mcause_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == StIssue && state_q != StIssue) begin
        mcause_q <= {1'b1, 27'b0, code};
      end
    end
  end

endmodule
